lc3b_seq_controller: RTL and testbench
======================================

Name:
lc3b_seq_controller

Overview:
Parametrised multicycle control FSM for the LC-3b core. It replaces the fixed-timing controller with a variable-latency memory handshake (mem_req/mem_rdy) and a run/idle gate. It adds illegal-opcode trapping and an optional memory watchdog. It drives the existing datapath mux selects and write enables, and decodes from the datapath IR register.

Parameters:
STATE_W, 5, width of state_id; must be >= 5 (elaboration error otherwise)
MEM_TIMEOUT, 15, maximum consecutive wait cycles without mem_rdy (used only with MEM_WDOG_EN)
TO_W, 4, width of the watchdog counter; must satisfy 2^TO_W > MEM_TIMEOUT

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
run  in  1  1 = fetch instructions; 0 = park in IDLE at the next instruction boundary
ir  in  16  current instruction from the datapath IR
N, Z, P  in  1 each  condition codes from the datapath
mem_rdy  in  1  memory completes the access in this cycle; sampled only while mem_req=1
state_id  out  STATE_W  current state encoding
wmar  out  1  load MAR
addr_sel  out  2  MAR source: 0 PC, 1 base+offset, 2 trapvect8<<1
wir  out  1  load IR from memory data
wpc  out  1  load PC
pc_sel  out  2  PC source: 0 PC+2, 1 PC+offset, 2 base register, 3 memory data
wrf  out  1  register file write
rf_dst_r7  out  1  1 = destination R7, 0 = ir[11:9]
rf_src_sel  out  2  RF data: 0 ALU/shifter, 1 memory, 2 PC, 3 address adder
lccr  out  1  load N/Z/P
aluop  out  2  0 ADD, 1 AND, 2 XOR, 3 pass
alushop  out  2  shift mode
mem_req  out  1  memory access request
mem_we  out  1  write access
mem_byte  out  1  byte access (LDB/STB)
illegal  out  1  sticky illegal-opcode flag
fault  out  1  sticky memory-timeout flag

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- State encoding: 0 IDLE, 1 FETCH0, 2 FETCH1, 3 DECODE, 4 EXEC_ALU, 5 EXEC_SHF, 6 EXEC_LEA, 7 EXEC_BR, 8 EXEC_JMP, 9 EXEC_JSR, 10 ADDR_LD, 11 MEM_RD, 12 WB_LD, 13 ADDR_ST, 14 MEM_WR, 15 TRAP0, 16 TRAP1, 17 ILLEGAL, 18 FAULT. state_id is zero-extended to STATE_W.
- Reset value: state IDLE. Every output is 0 during reset and in IDLE. Reset asserted mid-access drops mem_req immediately (asynchronously).
- Output decode: outputs are Moore, decoded from the state register. Exceptions: wir and wpc in wait states, which are gated by mem_rdy, and wpc in EXEC_BR, which depends on the branch condition.
- IDLE: go to FETCH0 when run=1.
- FETCH0: wmar=1, addr_sel=0. Next state FETCH1.
- FETCH1: mem_req=1. Hold while mem_rdy=0. On mem_rdy=1: wir=1, wpc=1, pc_sel=0, next state DECODE.
- DECODE on ir[15:12]:
  - 0001, 0101, 1001 -> EXEC_ALU; 1101 -> EXEC_SHF; 1110 -> EXEC_LEA; 0000 -> EXEC_BR
  - 1100 -> EXEC_JMP; 0100 -> EXEC_JSR; 0010, 0110 -> ADDR_LD; 0011, 0111 -> ADDR_ST
  - 1111 -> TRAP0; 1000, 1010, 1011 -> ILLEGAL
- EXEC_ALU: wrf=1, rf_src_sel=0, lccr=1. aluop: 0 for opcode 0001, 1 for 0101, 2 for 1001.
- EXEC_SHF: wrf=1, rf_src_sel=0, lccr=1, aluop=3, alushop=ir[5:4]. alushop is 0 in every other state.
- EXEC_LEA: wrf=1, rf_src_sel=3, lccr=0.
- EXEC_BR: wpc=(ir[11]&N)|(ir[10]&Z)|(ir[9]&P), pc_sel=1. nzp=000 is never taken.
- EXEC_JMP: wpc=1, pc_sel=2.
- EXEC_JSR: wrf=1, rf_dst_r7=1, rf_src_sel=2, wpc=1, pc_sel = ir[11] ? 1 : 2. The datapath reads the old PC in the same cycle.
- ADDR_LD / ADDR_ST: wmar=1, addr_sel=1. Next state MEM_RD / MEM_WR respectively.
- MEM_RD: mem_req=1, mem_byte=(opcode==0010). On mem_rdy go to WB_LD.
- WB_LD: wrf=1, rf_src_sel=1, lccr=1, mem_byte as in MEM_RD.
- MEM_WR: mem_req=1, mem_we=1, mem_byte=(opcode==0011). Completes on mem_rdy.
- TRAP0: wrf=1, rf_dst_r7=1, rf_src_sel=2, wmar=1, addr_sel=2. Next state TRAP1.
- TRAP1: mem_req=1. On mem_rdy: wpc=1, pc_sel=3.
- Instruction boundary: the last state of every instruction goes to FETCH0 if run=1, else IDLE. Deasserting run mid-instruction completes that instruction first.
- Latency with mem_rdy in the first wait cycle:
  - ALU/SHF/LEA/BR/JMP/JSR: 4 cycles
  - store and TRAP: 5 cycles
  - load: 6 cycles
  - Each extra wait cycle adds 1.
- ILLEGAL: illegal=1, all other outputs 0. Held until reset; run is ignored.
- FAULT: fault=1, all other outputs 0. Held until reset.

Optional Feature:
- Macro: MEM_WDOG_EN.
- When defined:
  - A TO_W-bit counter clears on entry to FETCH1, MEM_RD, MEM_WR or TRAP1.
  - It increments on each wait cycle with mem_rdy=0.
  - If mem_rdy=0 in the MEM_TIMEOUT-th consecutive wait cycle, the next state is FAULT.
  - mem_rdy=1 in that same cycle wins and completes normally.
- When undefined: no counter is instantiated, wait states hold indefinitely, and fault is tied to 0.

Test Plan:
- Reset, run=1, ir=16'h1042 (ADD), mem_rdy=1 permanently -> state_id 0,1,2,3,4,1. wir and wpc high in state 2. wrf=1, lccr=1, aluop=0 in state 4.
- ir=16'h6281 (LDW), mem_rdy low 3 cycles in MEM_RD -> MEM_RD held 4 cycles. WB_LD shows wrf=1, rf_src_sel=1, mem_byte=0.
- ir=16'h0A05 (BRnp), N=0 Z=1 P=0 -> wpc=0 in EXEC_BR. Repeat with P=1 -> wpc=1, pc_sel=1.
- ir=16'hF025 (TRAP) -> TRAP0 shows wrf=1, rf_dst_r7=1, addr_sel=2. TRAP1 with mem_rdy shows wpc=1, pc_sel=3.
- ir=16'hA000 -> state 17, illegal=1 held. run toggling has no effect; rst_n low returns state 0 with all outputs 0.
- MEM_WDOG_EN, MEM_TIMEOUT=15, mem_rdy=0 in FETCH1 -> state 18 and fault=1 after 15 wait cycles. Variant with mem_rdy=1 on cycle 15 -> DECODE.

Source files
------------

// File: rtl/lc3b_seq_controller.sv
// Multicycle LC-3b control FSM: variable-latency memory handshake, run/idle gating, illegal-opcode trap.
// Define MEM_WDOG_EN to build the memory watchdog that parks the FSM in FAULT on a stalled access.
module lc3b_seq_controller #(
   parameter int STATE_W     = 5,
   parameter int MEM_TIMEOUT = 15,
   parameter int TO_W        = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_run,
   input  logic [15:0]        i_ir,
   input  logic               i_n,
   input  logic               i_z,
   input  logic               i_p,
   input  logic               i_mem_rdy,
   output logic [STATE_W-1:0] o_state_id,
   output logic               o_wmar,
   output logic [1:0]         o_addr_sel,
   output logic               o_wir,
   output logic               o_wpc,
   output logic [1:0]         o_pc_sel,
   output logic               o_wrf,
   output logic               o_rf_dst_r7,
   output logic [1:0]         o_rf_src_sel,
   output logic               o_lccr,
   output logic [1:0]         o_aluop,
   output logic [1:0]         o_alushop,
   output logic               o_mem_req,
   output logic               o_mem_we,
   output logic               o_mem_byte,
   output logic               o_illegal,
   output logic               o_fault
);

   localparam logic [4:0] S_IDLE     = 5'd0;
   localparam logic [4:0] S_FETCH0   = 5'd1;
   localparam logic [4:0] S_FETCH1   = 5'd2;
   localparam logic [4:0] S_DECODE   = 5'd3;
   localparam logic [4:0] S_EXEC_ALU = 5'd4;
   localparam logic [4:0] S_EXEC_SHF = 5'd5;
   localparam logic [4:0] S_EXEC_LEA = 5'd6;
   localparam logic [4:0] S_EXEC_BR  = 5'd7;
   localparam logic [4:0] S_EXEC_JMP = 5'd8;
   localparam logic [4:0] S_EXEC_JSR = 5'd9;
   localparam logic [4:0] S_ADDR_LD  = 5'd10;
   localparam logic [4:0] S_MEM_RD   = 5'd11;
   localparam logic [4:0] S_WB_LD    = 5'd12;
   localparam logic [4:0] S_ADDR_ST  = 5'd13;
   localparam logic [4:0] S_MEM_WR   = 5'd14;
   localparam logic [4:0] S_TRAP0    = 5'd15;
   localparam logic [4:0] S_TRAP1    = 5'd16;
   localparam logic [4:0] S_ILLEGAL  = 5'd17;
   localparam logic [4:0] S_FAULT    = 5'd18;

   if (STATE_W < 5) begin : g_bad_state_w
      $error("lc3b_seq_controller: STATE_W must be at least 5");
   end
   if ((1 << TO_W) <= MEM_TIMEOUT) begin : g_bad_to_w
      $error("lc3b_seq_controller: TO_W too narrow for MEM_TIMEOUT");
   end

   logic [4:0] r_state;
   logic [4:0] w_next;
   logic [4:0] w_boundary;
   logic [3:0] w_opcode;
   logic       w_br_taken;
   logic       w_timeout;
   logic       w_unused_ir;

   assign w_opcode    = i_ir[15:12];
   assign w_boundary  = i_run ? S_FETCH0 : S_IDLE;
   assign w_br_taken  = (i_ir[11] & i_n) | (i_ir[10] & i_z) | (i_ir[9] & i_p);
   assign w_unused_ir = ^{i_ir[8:6], i_ir[3:0]};
   assign o_state_id  = STATE_W'(r_state);
   assign o_illegal   = (r_state == S_ILLEGAL);

   // Memory handshake: o_mem_req stays high for the whole access; the access completes in the
   // first cycle where o_mem_req=1 and i_mem_rdy=1. i_mem_rdy is ignored while o_mem_req=0.
`ifdef MEM_WDOG_EN
   localparam logic [TO_W-1:0] WD_LAST = TO_W'(MEM_TIMEOUT - 1);
   logic            w_in_wait;
   logic [TO_W-1:0] r_wcnt;

   assign w_in_wait = (r_state == S_FETCH1) || (r_state == S_MEM_RD) ||
                      (r_state == S_MEM_WR) || (r_state == S_TRAP1);

   // Counter holds the number of stalled cycles already spent in the current wait state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                       r_wcnt <= '0;
      else if (w_in_wait && !i_mem_rdy) r_wcnt <= r_wcnt + 1'b1;
      else                              r_wcnt <= '0;
   end

   assign w_timeout = w_in_wait && !i_mem_rdy && (r_wcnt == WD_LAST);
   assign o_fault   = (r_state == S_FAULT);
`else
   assign w_timeout = 1'b0;
   assign o_fault   = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:     if (i_run) w_next = S_FETCH0;
         S_FETCH0:   w_next = S_FETCH1;
         S_FETCH1:   if (i_mem_rdy) w_next = S_DECODE;
         S_DECODE: begin
            case (w_opcode)
               4'b0001, 4'b0101, 4'b1001: w_next = S_EXEC_ALU;
               4'b1101:                   w_next = S_EXEC_SHF;
               4'b1110:                   w_next = S_EXEC_LEA;
               4'b0000:                   w_next = S_EXEC_BR;
               4'b1100:                   w_next = S_EXEC_JMP;
               4'b0100:                   w_next = S_EXEC_JSR;
               4'b0010, 4'b0110:          w_next = S_ADDR_LD;
               4'b0011, 4'b0111:          w_next = S_ADDR_ST;
               4'b1111:                   w_next = S_TRAP0;
               default:                   w_next = S_ILLEGAL;
            endcase
         end
         S_EXEC_ALU, S_EXEC_SHF, S_EXEC_LEA,
         S_EXEC_BR, S_EXEC_JMP, S_EXEC_JSR,
         S_WB_LD:    w_next = w_boundary;
         S_ADDR_LD:  w_next = S_MEM_RD;
         S_MEM_RD:   if (i_mem_rdy) w_next = S_WB_LD;
         S_ADDR_ST:  w_next = S_MEM_WR;
         S_MEM_WR:   if (i_mem_rdy) w_next = w_boundary;
         S_TRAP0:    w_next = S_TRAP1;
         S_TRAP1:    if (i_mem_rdy) w_next = w_boundary;
         S_ILLEGAL:  w_next = S_ILLEGAL;
         S_FAULT:    w_next = S_FAULT;
         default:    w_next = S_IDLE;
      endcase
      if (w_timeout) w_next = S_FAULT;
   end

   always_comb begin
      o_wmar       = 1'b0;
      o_addr_sel   = 2'd0;
      o_wir        = 1'b0;
      o_wpc        = 1'b0;
      o_pc_sel     = 2'd0;
      o_wrf        = 1'b0;
      o_rf_dst_r7  = 1'b0;
      o_rf_src_sel = 2'd0;
      o_lccr       = 1'b0;
      o_aluop      = 2'd0;
      o_alushop    = 2'd0;
      o_mem_req    = 1'b0;
      o_mem_we     = 1'b0;
      o_mem_byte   = 1'b0;
      case (r_state)
         S_FETCH0:   o_wmar = 1'b1;
         S_FETCH1: begin
            o_mem_req = 1'b1;
            o_wir     = i_mem_rdy;
            o_wpc     = i_mem_rdy;
         end
         S_EXEC_ALU: begin
            o_wrf  = 1'b1;
            o_lccr = 1'b1;
            case (w_opcode)
               4'b0101: o_aluop = 2'd1;
               4'b1001: o_aluop = 2'd2;
               default: o_aluop = 2'd0;
            endcase
         end
         S_EXEC_SHF: begin
            o_wrf     = 1'b1;
            o_lccr    = 1'b1;
            o_aluop   = 2'd3;
            o_alushop = i_ir[5:4];
         end
         S_EXEC_LEA: begin
            o_wrf        = 1'b1;
            o_rf_src_sel = 2'd3;
         end
         S_EXEC_BR: begin
            o_wpc    = w_br_taken;
            o_pc_sel = 2'd1;
         end
         S_EXEC_JMP: begin
            o_wpc    = 1'b1;
            o_pc_sel = 2'd2;
         end
         // R7 captures the old PC in the same cycle PC is overwritten.
         S_EXEC_JSR: begin
            o_wrf        = 1'b1;
            o_rf_dst_r7  = 1'b1;
            o_rf_src_sel = 2'd2;
            o_wpc        = 1'b1;
            o_pc_sel     = i_ir[11] ? 2'd1 : 2'd2;
         end
         S_ADDR_LD, S_ADDR_ST: begin
            o_wmar     = 1'b1;
            o_addr_sel = 2'd1;
         end
         S_MEM_RD: begin
            o_mem_req  = 1'b1;
            o_mem_byte = (w_opcode == 4'b0010);
         end
         S_WB_LD: begin
            o_wrf        = 1'b1;
            o_rf_src_sel = 2'd1;
            o_lccr       = 1'b1;
            o_mem_byte   = (w_opcode == 4'b0010);
         end
         S_MEM_WR: begin
            o_mem_req  = 1'b1;
            o_mem_we   = 1'b1;
            o_mem_byte = (w_opcode == 4'b0011);
         end
         S_TRAP0: begin
            o_wrf        = 1'b1;
            o_rf_dst_r7  = 1'b1;
            o_rf_src_sel = 2'd2;
            o_wmar       = 1'b1;
            o_addr_sel   = 2'd2;
         end
         S_TRAP1: begin
            o_mem_req = 1'b1;
            o_wpc     = i_mem_rdy;
            o_pc_sel  = 2'd3;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_lc3b_seq_controller.sv
// Scoreboard bench for lc3b_seq_controller: per-cycle expected state/control words queued by the driver.
// Watchdog scenarios are exercised when MEM_WDOG_EN is defined; otherwise indefinite waits are checked.
module tb_lc3b_seq_controller;

   localparam int W = 26;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_run;
   logic [15:0] i_ir;
   logic        i_n, i_z, i_p;
   logic        i_mem_rdy;
   logic [4:0]  o_state_id;
   logic        o_wmar, o_wir, o_wpc, o_wrf, o_rf_dst_r7, o_lccr;
   logic [1:0]  o_addr_sel, o_pc_sel, o_rf_src_sel, o_aluop, o_alushop;
   logic        o_mem_req, o_mem_we, o_mem_byte, o_illegal, o_fault;
   logic [W-1:0] w_obs;

   logic [W-1:0] exp_q[$];
   string        tag_q[$];
   string        cur_tag;
   int           n_checks = 0;
   int           n_errors = 0;

   lc3b_seq_controller #(.STATE_W(5), .MEM_TIMEOUT(15), .TO_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .i_run(i_run), .i_ir(i_ir),
      .i_n(i_n), .i_z(i_z), .i_p(i_p), .i_mem_rdy(i_mem_rdy),
      .o_state_id(o_state_id), .o_wmar(o_wmar), .o_addr_sel(o_addr_sel),
      .o_wir(o_wir), .o_wpc(o_wpc), .o_pc_sel(o_pc_sel), .o_wrf(o_wrf),
      .o_rf_dst_r7(o_rf_dst_r7), .o_rf_src_sel(o_rf_src_sel), .o_lccr(o_lccr),
      .o_aluop(o_aluop), .o_alushop(o_alushop), .o_mem_req(o_mem_req),
      .o_mem_we(o_mem_we), .o_mem_byte(o_mem_byte), .o_illegal(o_illegal),
      .o_fault(o_fault)
   );

   assign w_obs = {o_state_id, o_wmar, o_addr_sel, o_wir, o_wpc, o_pc_sel, o_wrf,
                   o_rf_dst_r7, o_rf_src_sel, o_lccr, o_aluop, o_alushop,
                   o_mem_req, o_mem_we, o_mem_byte, o_illegal, o_fault};

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got state=%0d ctrl=%h, expected state=%0d ctrl=%h",
                  tag, got[W-1 -: 5], got[W-6:0], exp[W-1 -: 5], exp[W-6:0]);
      end
   endtask

   // Expected control word for a state, straight from the output table of the controller.
   function automatic logic [W-1:0] model(input logic [4:0] st, input logic rdy,
                                          input logic [15:0] ir, input logic n,
                                          input logic z, input logic p);
      logic wmar, wir, wpc, wrf, r7, lccr, req, we, byt, ill, flt;
      logic [1:0] asel, psel, src, aop, sop;
      logic [3:0] op;
      op = ir[15:12];
      {wmar, wir, wpc, wrf, r7, lccr, req, we, byt, ill, flt} = '0;
      {asel, psel, src, aop, sop} = '0;
      case (st)
         5'd1:  wmar = 1'b1;
         5'd2:  begin req = 1'b1; wir = rdy; wpc = rdy; end
         5'd4:  begin
            wrf = 1'b1; lccr = 1'b1;
            aop = (op == 4'b0101) ? 2'd1 : (op == 4'b1001) ? 2'd2 : 2'd0;
         end
         5'd5:  begin wrf = 1'b1; lccr = 1'b1; aop = 2'd3; sop = ir[5:4]; end
         5'd6:  begin wrf = 1'b1; src = 2'd3; end
         5'd7:  begin wpc = (ir[11] & n) | (ir[10] & z) | (ir[9] & p); psel = 2'd1; end
         5'd8:  begin wpc = 1'b1; psel = 2'd2; end
         5'd9:  begin wrf = 1'b1; r7 = 1'b1; src = 2'd2; wpc = 1'b1; psel = ir[11] ? 2'd1 : 2'd2; end
         5'd10, 5'd13: begin wmar = 1'b1; asel = 2'd1; end
         5'd11: begin req = 1'b1; byt = (op == 4'b0010); end
         5'd12: begin wrf = 1'b1; src = 2'd1; lccr = 1'b1; byt = (op == 4'b0010); end
         5'd14: begin req = 1'b1; we = 1'b1; byt = (op == 4'b0011); end
         5'd15: begin wrf = 1'b1; r7 = 1'b1; src = 2'd2; wmar = 1'b1; asel = 2'd2; end
         5'd16: begin req = 1'b1; wpc = rdy; psel = 2'd3; end
         5'd17: ill = 1'b1;
         5'd18: flt = 1'b1;
         default: ;
      endcase
      return {st, wmar, asel, wir, wpc, psel, wrf, r7, src, lccr, aop, sop, req, we, byt, ill, flt};
   endfunction

   function automatic logic rnd1();
      return 1'($urandom_range(0, 1));
   endfunction

   // One clock of stimulus: called at posedge+1, expectation covers the cycle until the next posedge.
   task automatic drive(input logic [4:0] st, input logic rdy);
      i_mem_rdy = rdy;
      exp_q.push_back(model(st, rdy, i_ir, i_n, i_z, i_p));
      tag_q.push_back(cur_tag);
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [15:0] ir, input int waits);
      i_ir = ir;
      drive(5'd1, rnd1());
      repeat (waits) drive(5'd2, 1'b0);
      drive(5'd2, 1'b1);
      drive(5'd3, rnd1());
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      #1;
      check(tag, w_obs, '0);
      i_run = 1'b0;
      @(negedge clk);
      check({tag, "_hold"}, w_obs, '0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin : monitor
      logic [W-1:0] e;
      string t;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         check(t, w_obs, e);
      end
   end

   initial begin
      int nw;
      rst_n = 1'b0; i_run = 1'b0; i_ir = '0;
      i_n = 1'b0; i_z = 1'b0; i_p = 1'b0; i_mem_rdy = 1'b1;
      #2;
      check("reset", w_obs, '0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      cur_tag = "idle";
      drive(5'd0, rnd1());
      drive(5'd0, rnd1());
      i_run = 1'b1;
      drive(5'd0, rnd1());

      cur_tag = "add";  fetch(16'h1042, 0); drive(5'd4, rnd1());
      cur_tag = "and";  fetch({4'b0101, 12'($urandom)}, 1); drive(5'd4, rnd1());
      cur_tag = "xor";  fetch({4'b1001, 12'($urandom)}, 2); drive(5'd4, rnd1());
      cur_tag = "shf";
      for (int k = 0; k < 4; k++) begin
         fetch({4'b1101, 6'($urandom), 2'(k), 4'($urandom)}, 0);
         drive(5'd5, rnd1());
      end
      cur_tag = "lea";  fetch({4'b1110, 12'($urandom)}, 0); drive(5'd6, rnd1());

      cur_tag = "br_nt"; i_n = 1'b0; i_z = 1'b1; i_p = 1'b0;
      fetch(16'h0A05, 0); drive(5'd7, rnd1());
      cur_tag = "br_tk"; i_p = 1'b1;
      fetch(16'h0A05, 0); drive(5'd7, rnd1());
      cur_tag = "br_nzp0"; i_n = 1'b1; i_z = 1'b1; i_p = 1'b1;
      fetch({7'b0000000, 9'($urandom)}, 0); drive(5'd7, rnd1());

      cur_tag = "jmp";    fetch(16'hC1C0, 0); drive(5'd8, rnd1());
      cur_tag = "jsr";    fetch({5'b01001, 11'($urandom)}, 0); drive(5'd9, rnd1());
      cur_tag = "jsrr";   fetch({5'b01000, 11'($urandom)}, 1); drive(5'd9, rnd1());

      cur_tag = "ldw";
      fetch(16'h6281, 0); drive(5'd10, rnd1());
      repeat (3) drive(5'd11, 1'b0);
      drive(5'd11, 1'b1); drive(5'd12, rnd1());
      cur_tag = "ldb";
      nw = $urandom_range(0, 4);
      fetch({4'b0010, 12'($urandom)}, 0); drive(5'd10, rnd1());
      repeat (nw) drive(5'd11, 1'b0);
      drive(5'd11, 1'b1); drive(5'd12, rnd1());
      cur_tag = "stw";
      nw = $urandom_range(0, 4);
      fetch({4'b0111, 12'($urandom)}, 0); drive(5'd13, rnd1());
      repeat (nw) drive(5'd14, 1'b0);
      drive(5'd14, 1'b1);
      cur_tag = "stb";
      fetch({4'b0011, 12'($urandom)}, 0); drive(5'd13, rnd1());
      drive(5'd14, 1'b1);

      cur_tag = "trap";
      fetch(16'hF025, 0); drive(5'd15, rnd1());
      drive(5'd16, 1'b0); drive(5'd16, 1'b0); drive(5'd16, 1'b1);

      cur_tag = "run_off";
      fetch(16'h6281, 0); drive(5'd10, rnd1());
      i_run = 1'b0;
      drive(5'd11, 1'b1); drive(5'd12, rnd1());
      drive(5'd0, rnd1()); drive(5'd0, rnd1());
      i_run = 1'b1;
      drive(5'd0, rnd1());

      cur_tag = "rst_mid";
      i_ir = 16'h1042;
      drive(5'd1, rnd1());
      i_mem_rdy = 1'b0;
      #1;
      check("rst_mid_req", w_obs, model(5'd2, 1'b0, i_ir, i_n, i_z, i_p));
      do_reset("rst_mid");
      i_run = 1'b1;
      drive(5'd0, rnd1());

`ifdef MEM_WDOG_EN
      cur_tag = "wdog_edge";
      fetch(16'h1042, 14); drive(5'd4, rnd1());
      cur_tag = "wdog_to";
      drive(5'd1, rnd1());
      repeat (15) drive(5'd2, 1'b0);
      repeat (3) begin
         i_run = rnd1();
         drive(5'd18, rnd1());
      end
      do_reset("wdog_rst");
      i_run = 1'b1;
      drive(5'd0, rnd1());
`else
      cur_tag = "long_wait";
      fetch(16'h1042, 30); drive(5'd4, rnd1());
`endif

      cur_tag = "illegal";
      fetch(16'hA000, 0);
      repeat (4) begin
         i_run = rnd1();
         drive(5'd17, rnd1());
      end
      do_reset("ill_rst");
      i_run = 1'b1;
      drive(5'd0, rnd1());
      cur_tag = "illegal_b";
      fetch({4'b1011, 12'($urandom)}, 0);
      drive(5'd17, rnd1());
      i_run = 1'b0;
      drive(5'd17, rnd1());
      do_reset("ill_rst_b");

      if (exp_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, required finish before 200000");
      $fatal(1);
   end

endmodule
